sys_bus_master: RTL

- Initiator on the system bus: turns a command stream (write/read, address, data) into single-cycle bus write/read strobes.
- Waits for the responder's acknowledge and returns a status and read-data stream.
- Sits between a host-side command source (DMA descriptor engine, test sequencer) and register blocks that registered-ack one cycle after the strobe.
- One transaction outstanding at a time, with a bounded timeout.

---
 rtl/sys_bus_if.sv | 37 +++
 rtl/sys_bus_master.sv | 110 +++++++++++
 2 files changed

// File: rtl/sys_bus_if.sv
// Command/response and system-bus signals between a host command source,
// sys_bus_master, and register-block responders.
interface sys_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_vld;
    logic          cmd_rdy;
    logic          cmd_wen;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_sts;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_wen;
    logic          bus_ren;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          bus_err;

    modport master (
        input  cmd_vld, cmd_wen, cmd_addr, cmd_wdata, rsp_rdy,
               bus_rdata, bus_ack, bus_err,
        output cmd_rdy, rsp_vld, rsp_rdata, rsp_sts,
               bus_addr, bus_wdata, bus_wen, bus_ren
    );

    modport slave (
        output cmd_vld, cmd_wen, cmd_addr, cmd_wdata, rsp_rdy,
               bus_rdata, bus_ack, bus_err,
        input  cmd_rdy, rsp_vld, rsp_rdata, rsp_sts,
               bus_addr, bus_wdata, bus_wen, bus_ren
    );
endinterface

// File: rtl/sys_bus_master.sv
// Single-outstanding system-bus initiator: command in, one-cycle strobe out,
// wait for ack or timeout, hand back status and read data.
//
// state | meaning
// IDLE  | ready for a command; stray acks dropped
// REQ   | one-cycle write/read strobe on the bus
// WAIT  | waiting for bus_ack or timeout expiry
// RSP   | response held until rsp_rdy
module sys_bus_master #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 64,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rstn,
    sys_bus_if.master     bus,
    output logic          busy,
    output logic [CW-1:0] cnt_tmo
);
    localparam int            TW       = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TMO > 0) ? TW'(TMO - 1) : '0;
    localparam logic [1:0]    STS_OK   = 2'd0;
    localparam logic [1:0]    STS_ERR  = 2'd1;
    localparam logic [1:0]    STS_TMO  = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t        state, state_nxt;
    logic          accept, done_ack, done_tmo;
    logic          wen_q;
    logic [TW-1:0] tmo_cnt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_ack  = 1'b0;
        done_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_vld && bus.cmd_rdy) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                // ack is checked first so it beats a timeout in the same cycle
                if (bus.bus_ack) begin
                    done_ack  = 1'b1;
                    state_nxt = RSP;
                end else if (TMO != 0 && tmo_cnt == '0) begin
                    done_tmo  = 1'b1;
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_vld && bus.rsp_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            tmo_cnt       <= '0;
            busy          <= 1'b0;
            cnt_tmo       <= '0;
            bus.cmd_rdy   <= 1'b0;
            bus.rsp_vld   <= 1'b0;
            bus.rsp_sts   <= STS_OK;
            bus.rsp_rdata <= {DW{1'b0}};
            bus.bus_addr  <= {AW{1'b0}};
            bus.bus_wdata <= {DW{1'b0}};
            bus.bus_wen   <= 1'b0;
            bus.bus_ren   <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            bus.cmd_rdy <= (state_nxt == IDLE);
            bus.rsp_vld <= (state_nxt == RSP);
            bus.bus_wen <= accept && bus.cmd_wen;
            bus.bus_ren <= accept && !bus.cmd_wen;

            if (accept) begin
                wen_q         <= bus.cmd_wen;
                bus.bus_addr  <= bus.cmd_addr;
                bus.bus_wdata <= bus.cmd_wdata;
            end

            // down-counter reaches zero on the last permitted wait cycle
            if (state == REQ) tmo_cnt <= TMO_LAST;
            else if (state == WAIT) tmo_cnt <= tmo_cnt - 1'b1;

            if (done_ack) begin
                bus.rsp_sts   <= bus.bus_err ? STS_ERR : STS_OK;
                bus.rsp_rdata <= (!wen_q && !bus.bus_err) ? bus.bus_rdata : {DW{1'b0}};
            end else if (done_tmo) begin
                bus.rsp_sts   <= STS_TMO;
                bus.rsp_rdata <= {DW{1'b0}};
                if (cnt_tmo != {CW{1'b1}}) cnt_tmo <= cnt_tmo + 1'b1;
            end else if (state == RSP && state_nxt == IDLE) begin
                bus.rsp_sts   <= STS_OK;
                bus.rsp_rdata <= {DW{1'b0}};
            end
        end
    end
endmodule
